// File: rtl/heap_arb.sv
// heap_arb: two-client round-robin arbiter and sequencer for the heap.
// Pre-checks full/empty, issues one heap op at a time, acks with data.
module heap_arb #(
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req0,
  input  logic       op0,
  input  logic [7:0] wdata0,
  output logic       ack0,
  input  logic       req1,
  input  logic       op1,
  input  logic [7:0] wdata1,
  output logic       ack1,
  output logic [7:0] rdata,
  output logic       err,
  output logic       h_push,
  output logic       h_pop,
  output logic [7:0] h_din,
  input  logic [7:0] h_dout,
  input  logic [7:0] h_size,
  input  logic       h_done,
  input  logic       h_valid,
  output logic [7:0] err_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SETTLE,
    S_RESP
  } state_t;

  state_t          state;
  logic            ptr;
  logic            win_q;
  logic [TO_W-1:0] to_cnt;

  logic       any_req;
  logic       win;
  logic       win_op;
  logic [7:0] win_data;
  logic       rej;
  logic       stall;

  always_comb begin
    any_req  = req0 | req1;
    win      = (req0 && req1) ? ptr : req1;
    win_op   = win ? op1 : op0;
    win_data = win ? wdata1 : wdata0;
    rej      = win_op ? (h_size == 8'h00)
                      : (h_size == 8'hFF);
    // a pop must see a settled top before it is captured
    stall    = win_op && !rej && !h_valid;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_IDLE;
      ptr     <= 1'b0;
      win_q   <= 1'b0;
      to_cnt  <= '0;
      ack0    <= 1'b0;
      ack1    <= 1'b0;
      err     <= 1'b0;
      h_push  <= 1'b0;
      h_pop   <= 1'b0;
      rdata   <= 8'h00;
      h_din   <= 8'h00;
      err_cnt <= 8'h00;
    end else begin
      ack0   <= 1'b0;
      ack1   <= 1'b0;
      h_push <= 1'b0;
      h_pop  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (any_req && !stall) begin
            win_q <= win;
            h_din <= win_data;
            if (rej) begin
              err   <= 1'b1;
              ack0  <= !win;
              ack1  <= win;
              state <= S_RESP;
            end else begin
              if (win_op) rdata <= h_dout;
              h_push <= !win_op;
              h_pop  <= win_op;
              state  <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          to_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          if (h_done) begin
            err   <= 1'b0;
            state <= S_SETTLE;
          end else if (to_cnt == TO_W'(TIMEOUT)) begin
            err   <= 1'b1;
            ack0  <= !win_q;
            ack1  <= win_q;
            state <= S_RESP;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        S_SETTLE: begin
          ack0  <= !win_q;
          ack1  <= win_q;
          state <= S_RESP;
        end
        S_RESP: begin
          ptr <= !win_q;
          if (err && err_cnt != 8'hFF)
            err_cnt <= err_cnt + 8'h01;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_heap_arb.sv
// tb_heap_arb: random two-client traffic against a queue-based heap
// and a transaction-level reference of arbitration and results.
module tb_heap_arb;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req0 = 1'b0, op0 = 1'b0;
  logic       req1 = 1'b0, op1 = 1'b0;
  logic [7:0] wdata0 = 8'h00, wdata1 = 8'h00;
  logic       ack0, ack1, err, h_push, h_pop;
  logic [7:0] rdata, h_din, err_cnt;
  logic [7:0] h_dout, h_size;
  logic       h_done, h_valid;

  heap_arb #(.TIMEOUT(TIMEOUT), .TO_W(7)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .op0(op0), .wdata0(wdata0), .ack0(ack0),
    .req1(req1), .op1(op1), .wdata1(wdata1), .ack1(ack1),
    .rdata(rdata), .err(err),
    .h_push(h_push), .h_pop(h_pop), .h_din(h_din),
    .h_dout(h_dout), .h_size(h_size), .h_done(h_done),
    .h_valid(h_valid), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];

  function automatic int qmax_idx(input bq_t q);
    int m = 0;
    for (int i = 1; i < q.size(); i++)
      if (q[i] > q[m]) m = i;
    return m;
  endfunction

  function automatic logic [7:0] qmax(input bq_t q);
    if (q.size() == 0) return 8'h00;
    return q[qmax_idx(q)];
  endfunction

  // heap stand-in: max-heap contents, random op latency
  bq_t        hp;
  logic       busy, bop;
  logic       hang = 1'b0, force_full = 1'b0;
  logic [7:0] bdin, hp_top;
  logic [8:0] hp_n;
  int         bcnt;

  assign h_size  = force_full ? 8'hFF : hp_n[7:0];
  assign h_dout  = hp_top;
  assign h_valid = !busy && (h_size != 8'h00);

  always @(posedge clk) begin
    if (!reset) begin
      hp.delete();
      busy   <= 1'b0;
      bop    <= 1'b0;
      bdin   <= 8'h00;
      bcnt   <= 0;
      h_done <= 1'b0;
      hp_n   <= '0;
      hp_top <= 8'h00;
    end else begin
      h_done <= 1'b0;
      if (h_push || h_pop) begin
        busy <= 1'b1;
        bop  <= h_pop;
        bdin <= h_din;
        bcnt <= $urandom_range(1, 4);
      end else if (busy && !hang) begin
        if (bcnt > 1) begin
          bcnt <= bcnt - 1;
        end else begin
          if (bop) begin
            if (hp.size() > 0) hp.delete(qmax_idx(hp));
          end else begin
            hp.push_back(bdin);
          end
          hp_n   <= 9'(hp.size());
          hp_top <= qmax(hp);
          busy   <= 1'b0;
          h_done <= 1'b1;
        end
      end
    end
  end

  // reference state
  bq_t ref_q;
  bit  exp_ptr;
  int  exp_errs;
  int  n_checks = 0;
  int  n_fail = 0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req0 = 1'b0;
    req1 = 1'b0;
    hang = 1'b0;
    force_full = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    ref_q.delete();
    exp_ptr = 1'b0;
    exp_errs = 0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack0"}, ack0, 0);
    check({tag, "_ack1"}, ack1, 0);
    check({tag, "_err"}, err, 0);
    check({tag, "_push"}, h_push, 0);
    check({tag, "_pop"}, h_pop, 0);
    check({tag, "_rdata"}, rdata, 0);
    check({tag, "_din"}, h_din, 0);
    check({tag, "_errcnt"}, err_cnt, 0);
  endtask

  task automatic present(input bit c, input bit op,
                         input logic [7:0] d);
    if (c) begin
      req1 = 1'b1; op1 = op; wdata1 = d;
    end else begin
      req0 = 1'b1; op0 = op; wdata0 = d;
    end
  endtask

  // runs one transaction from an IDLE-cycle negedge to the next one
  task automatic serve();
    bit         w, eop, eerr;
    logic [7:0] ed, erd;
    int         esz, lat, npu, npo, sd;
    w    = (req0 && req1) ? exp_ptr : req1;
    eop  = w ? op1 : op0;
    ed   = w ? wdata1 : wdata0;
    esz  = force_full ? 255 : ref_q.size();
    eerr = eop ? (esz == 0) : (esz == 255);
    erd  = qmax(ref_q);
    lat = 1; npu = 0; npo = 0; sd = -1;
    forever begin
      @(negedge clk);
      lat++;
      if (sd >= 0) sd++;
      if (h_done) sd = 0;
      check("push_pop_excl", h_push & h_pop, 0);
      if (h_push) begin
        npu++;
        check("h_din", h_din, ed);
      end
      if (h_pop) npo++;
      if (ack0 || ack1) break;
      if (lat > 300) begin
        check("ack_wait", ack0 | ack1, 1);
        return;
      end
    end
    check("ack0", ack0, !w);
    check("ack1", ack1, w);
    check("err", err, eerr);
    if (eop && !eerr) check("rdata", rdata, erd);
    if (eerr) check("err_lat", lat, 2);
    else check("done_lat", sd, 2);
    check("push_cnt", npu, !eerr && !eop);
    check("pop_cnt", npo, !eerr && eop);
    if (eerr) begin
      if (exp_errs < 255) exp_errs++;
    end else if (eop) begin
      ref_q.delete(qmax_idx(ref_q));
    end else begin
      ref_q.push_back(ed);
    end
    exp_ptr = !w;
    if (w) req1 = 1'b0;
    else req0 = 1'b0;
    @(negedge clk);
    check("ack_pulse", ack0 | ack1, 0);
    check("err_cnt", err_cnt, exp_errs);
    if (!force_full) check("h_size", h_size, ref_q.size());
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end expected end");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    do_reset();
    check_zero("rst");

    present(1, 1, 8'h00); serve();
    present(0, 0, 8'h42); serve();
    present(1, 1, 8'h00); serve();
    present(1, 0, 8'h05); serve();
    present(0, 1, 8'h00); serve();

    do_reset();
    present(0, 0, 8'hA0);
    present(1, 0, 8'hB0);
    serve();
    repeat (6) begin
      if (!req0) present(0, 0, 8'($urandom));
      if (!req1) present(1, 0, 8'($urandom));
      serve();
    end

    repeat (400) begin
      if (!req0 && $urandom_range(0, 3) != 0)
        present(0, 1'($urandom_range(0, 1)), 8'($urandom));
      if (!req1 && $urandom_range(0, 3) != 0)
        present(1, 1'($urandom_range(0, 1)), 8'($urandom));
      if (!req0 && !req1)
        present(0, 1'($urandom_range(0, 1)), 8'($urandom));
      serve();
    end

    force_full = 1'b1;
    present(0, 0, 8'h11); serve();
    present(1, 0, 8'h22); serve();
    force_full = 1'b0;

    hang = 1'b1;
    present(0, 0, 8'h33);
    lat = 0;
    while (!h_push && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("to_push_seen", h_push, 1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!(ack0 || ack1) && lat < TIMEOUT + 20);
    check("to_lat", lat, TIMEOUT + 2);
    check("to_ack0", ack0, 1);
    check("to_err", err, 1);
    if (exp_errs < 255) exp_errs++;
    exp_ptr = 1'b1;
    req0 = 1'b0;
    @(negedge clk);
    check("to_err_cnt", err_cnt, exp_errs);

    present(0, 0, 8'h44);
    lat = 0;
    while (!h_push && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("wr_push_seen", h_push, 1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    req0 = 1'b0;
    @(negedge clk);
    check_zero("wrst");
    hang = 1'b0;
    reset = 1'b1;
    ref_q.delete();
    exp_ptr = 1'b0;
    exp_errs = 0;
    present(0, 0, 8'h55);
    present(1, 0, 8'h66);
    serve();
    serve();

    do_reset();
    repeat (260) begin
      present(0, 1, 8'h00);
      serve();
    end
    check("sat_err_cnt", err_cnt, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/heap_arb.md
Name: heap_arb

Overview:
- Two-client arbiter and sequencer for the 256-entry, 8-bit heap block (push/pop/din/dout/size/done/valid interface).
- Takes level-held push/pop requests from two clients and serializes them onto the heap with round-robin fairness.
- Pre-checks full/empty, captures the popped top value, and returns a one-cycle acknowledge with data and error status.
- Sits between the heap and its users; it is the only driver of the heap's push/pop/din inputs.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT for h_done before the op is aborted with error
TO_W, 7, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous reset, active-low (0 = reset)
req0  in  1  client 0 request; held high until ack0
op0  in  1  client 0 op: 0 = push, 1 = pop; stable while req0 high
wdata0  in  8  client 0 push data; stable while req0 high
ack0  out  1  one-cycle completion pulse to client 0
req1, op1, wdata1, ack1  —  same as client 0, for client 1
rdata  out  8  popped value, valid with ack0/ack1 when op = pop and err = 0
err  out  1  valid with ack: 1 = rejected (full/empty) or timed out
h_push  out  1  one-cycle push start to heap
h_pop  out  1  one-cycle pop start to heap
h_din  out  8  push data to heap
h_dout  in  8  heap top value
h_size  in  8  heap occupancy
h_done  in  1  heap op-complete pulse
h_valid  in  1  heap idle and non-empty; h_dout holds the top
err_cnt  out  8  saturating count of err acks

Behaviour:
- Reset (reset = 0 at a clk edge):
  - State = IDLE; ptr = 0 (client 0 has priority).
  - ack0, ack1, err, h_push, h_pop, rdata, h_din, err_cnt all = 0; timeout counter = 0.
  - Applies in any state, including mid-WAIT. No ack is issued for the in-flight op. The heap is reset by the same signal in the system.
- States: IDLE, ISSUE, WAIT, SETTLE, RESP.
- IDLE:
  - If no req, stay.
  - If exactly one req, it wins.
  - If both req, client ptr wins.
  - On a win, latch the winner id, op and wdata (wdata to h_din).
- Error pre-check, done in IDLE:
  - Push with h_size == 255 → err = 1, go to RESP.
  - Pop with h_size == 0 → err = 1, go to RESP.
  - The heap sees no push/pop in either case.
- Non-error pop: rdata <= h_dout in the same IDLE cycle; h_valid must be 1 here.
- Non-error op: go to ISSUE.
- ISSUE (1 cycle): assert h_push or h_pop for exactly this cycle; clear the timeout counter; go to WAIT.
- WAIT:
  - Increment the timeout counter each cycle.
  - On h_done = 1 → SETTLE, err = 0.
  - If the counter reaches TIMEOUT first → RESP, err = 1.
- SETTLE (1 cycle): lets the heap's working flags clear and top-of-heap readback settle; then → RESP.
- RESP (1 cycle):
  - Pulse ack of the latched winner only; err and rdata are held valid this cycle.
  - ptr <= other client.
  - err_cnt increments (saturating at 255) if err.
  - → IDLE.
- Handshake:
  - A client must drop req or present a new request in the cycle after its ack.
  - Because RESP → IDLE, the earliest re-arbitration is the cycle after ack.
- Latency:
  - Error op: req to ack = 2 cycles (IDLE, RESP).
  - Good op: ack = h_done + 2 cycles.
- rdata and err hold their last values between acks. The value of rdata on a push ack is don't-care.
- h_push and h_pop are never high together; neither is asserted outside ISSUE.
- Requests arriving while busy are held by the client and arbitrated on the next IDLE.
- ptr updates only on ack, including error acks.

Test Plan:
- Empty heap, req0 push 0x42 → one h_push pulse with h_din = 0x42; after h_done, ack0 with err = 0; h_size becomes 1; err_cnt = 0.
- Empty heap, req1 pop → ack1 2 cycles after req with err = 1; h_pop never asserted; err_cnt = 1.
- Heap holding a top of 0x05, req0 pop → rdata = 0x05 with ack0, err = 0; h_size decrements by 1.
- req0 and req1 both asserted from IDLE after reset (both push) → client 0 acked first, then client 1. Repeat with both held → service alternates 1, 0, 1, 0 with no starvation.
- h_size forced to 255, push request → err ack with no h_push. Separately, h_done held low → err ack exactly TIMEOUT + 2 cycles after h_push.
- reset driven to 0 during WAIT → next cycle: IDLE, no ack, all outputs 0, ptr = 0; a fresh request then completes normally.
